dmem_arbiter: RTL and testbench

DMEM_ARBITER -- requirements
Module: dmem_arbiter

---
 rtl/dmem_arbiter.sv | 172 +++++++++++++++++
 tb/tb_dmem_arbiter.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/dmem_arbiter.sv
// Purpose : arbitrates one single-port data memory between the CPU core and a
//           console/loader port, with anti-starvation and console lock-out.
// Latency : grant and memory strobe are combinational; read data returns the
//           cycle after the grant (rvalid to the owner of that read).
// Backpressure: a requester is stalled by its gnt being low; it must hold its
//           request until granted. There is no queueing inside the block.
//
// Ports:
//   clk, rst                      clock, synchronous active-high reset
//   core_req/we/addr/wdata        core request (we == 0 means read)
//   core_gnt/rvalid/rdata         core grant, read-return valid and data
//   con_req/we/addr/wdata         console request, same meaning as core_*
//   con_lock                      console exclusive ownership while high
//   con_gnt/rvalid/rdata          console grant, read-return valid and data
//   mem_en/we/addr/wdata          memory command port (zero when idle)
//   mem_rdata                     memory read data, one cycle after a read
module dmem_arbiter #(
  parameter int ADDR_BITS  = 14,
  parameter int STARVE_MAX = 4
) (
  input  logic                 clk,
  input  logic                 rst,

  input  logic                 core_req,
  input  logic [3:0]           core_we,
  input  logic [ADDR_BITS-1:0] core_addr,
  input  logic [31:0]          core_wdata,
  output logic                 core_gnt,
  output logic                 core_rvalid,
  output logic [31:0]          core_rdata,

  input  logic                 con_req,
  input  logic [3:0]           con_we,
  input  logic [ADDR_BITS-1:0] con_addr,
  input  logic [31:0]          con_wdata,
  input  logic                 con_lock,
  output logic                 con_gnt,
  output logic                 con_rvalid,
  output logic [31:0]          con_rdata,

  output logic                 mem_en,
  output logic [3:0]           mem_we,
  output logic [ADDR_BITS-1:0] mem_addr,
  output logic [31:0]          mem_wdata,
  input  logic [31:0]          mem_rdata
);

  typedef enum logic [1:0] {
    PRI_CORE = 2'd0,
    PRI_CON  = 2'd1,
    LOCKED   = 2'd2
  } state_e;

  localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);

  state_e     state_q, state_d;
  logic [3:0] starve_q, starve_d;
  logic [3:0] starve_next;
  logic       core_rd_q, core_rd_d;
  logic       con_rd_q, con_rd_d;

  // ---------------------------------------------------------------------------
  // Grant decision: purely from the registered priority state and the
  // requests presented this cycle. Nothing is granted while in reset.
  // ---------------------------------------------------------------------------
  always_comb begin
    core_gnt = 1'b0;
    con_gnt  = 1'b0;
    if (!rst) begin
      case (state_q)
        PRI_CON: begin
          con_gnt  = con_req;
          core_gnt = core_req & ~con_req;
        end
        LOCKED: begin
          // Core is fenced off completely while the console owns memory.
          con_gnt  = con_req;
        end
        default: begin
          core_gnt = core_req;
          con_gnt  = con_req & ~core_req;
        end
      endcase
    end
  end

  // Memory command mux; all fields are zero when nobody is granted.
  always_comb begin
    mem_en    = core_gnt | con_gnt;
    mem_we    = '0;
    mem_addr  = '0;
    mem_wdata = '0;
    if (core_gnt) begin
      mem_we    = core_we;
      mem_addr  = core_addr;
      mem_wdata = core_wdata;
    end else if (con_gnt) begin
      mem_we    = con_we;
      mem_addr  = con_addr;
      mem_wdata = con_wdata;
    end
  end

  // ---------------------------------------------------------------------------
  // Starvation counter and priority state.
  // The counter tracks consecutive cycles the console asked and was refused.
  // When it reaches the limit the console gets exactly one priority access,
  // after which priority reverts to the core.
  // ---------------------------------------------------------------------------
  always_comb begin
    starve_next = 4'd0;
    if (con_req && !con_gnt) begin
      starve_next = (starve_q >= STARVE_LIM) ? STARVE_LIM : starve_q + 4'd1;
    end
  end

  always_comb begin
    state_d  = state_q;
    starve_d = starve_next;
    if (con_lock) begin
      // Lock wins over both the starvation promotion and the PRI_CON return.
      state_d = LOCKED;
    end else begin
      case (state_q)
        PRI_CORE: if (starve_next == STARVE_LIM) state_d = PRI_CON;
        PRI_CON:  if (con_gnt)                   state_d = PRI_CORE;
        LOCKED:                                  state_d = PRI_CORE;
        default:                                 state_d = PRI_CORE;
      endcase
    end
    // Entering the locked state starts the console with a clean slate.
    if (state_d == LOCKED && state_q != LOCKED) begin
      starve_d = 4'd0;
    end
  end

  // Remember which requester owns the read that memory answers next cycle.
  always_comb begin
    core_rd_d = core_gnt & (core_we == 4'h0);
    con_rd_d  = con_gnt  & (con_we  == 4'h0);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= PRI_CORE;
      starve_q  <= 4'd0;
      core_rd_q <= 1'b0;
      con_rd_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      starve_q  <= starve_d;
      core_rd_q <= core_rd_d;
      con_rd_q  <= con_rd_d;
    end
  end

  // Read return. Gating with rst drops a read that was granted just before
  // reset was asserted, since its owner is being reset too.
  assign core_rvalid = core_rd_q & ~rst;
  assign con_rvalid  = con_rd_q  & ~rst;
  assign core_rdata  = mem_rdata;
  assign con_rdata   = mem_rdata;

  // Structural invariants.
  a_one_grant: assert property (@(posedge clk) disable iff (rst)
                                !(core_gnt && con_gnt));
  a_one_rvalid: assert property (@(posedge clk) disable iff (rst)
                                 !(core_rvalid && con_rvalid));
  a_lock_fence: assert property (@(posedge clk) disable iff (rst)
                                 (state_q == LOCKED) |-> !core_gnt);

endmodule

// File: tb/tb_dmem_arbiter.sv
// Purpose : directed scoreboard bench for dmem_arbiter.
// Latency : stimulus pushes expected grant/memory port per cycle and expected
//           read returns; a negedge monitor pops and compares.
// Backpressure: none; requests are held by the directed sequence itself.
module tb_dmem_arbiter;

  localparam int AB     = 14;
  localparam int G_NONE = 0;
  localparam int G_CORE = 1;
  localparam int G_CON  = 2;

  logic          clk = 1'b0;
  logic          rst;
  logic          core_req, con_req, con_lock;
  logic [3:0]    core_we, con_we;
  logic [AB-1:0] core_addr, con_addr;
  logic [31:0]   core_wdata, con_wdata;
  logic          core_gnt, core_rvalid, con_gnt, con_rvalid;
  logic [31:0]   core_rdata, con_rdata;
  logic          mem_en;
  logic [3:0]    mem_we;
  logic [AB-1:0] mem_addr;
  logic [31:0]   mem_wdata;
  logic [31:0]   mem_rdata = 32'h0;

  always #5 clk = ~clk;

  dmem_arbiter #(.ADDR_BITS(AB), .STARVE_MAX(4)) dut (
    .clk(clk), .rst(rst),
    .core_req(core_req), .core_we(core_we), .core_addr(core_addr),
    .core_wdata(core_wdata), .core_gnt(core_gnt), .core_rvalid(core_rvalid),
    .core_rdata(core_rdata),
    .con_req(con_req), .con_we(con_we), .con_addr(con_addr),
    .con_wdata(con_wdata), .con_lock(con_lock), .con_gnt(con_gnt),
    .con_rvalid(con_rvalid), .con_rdata(con_rdata),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  // Memory read data is a fixed pattern of the address, one cycle late.
  function automatic logic [31:0] pat(input logic [AB-1:0] a);
    return {16'hBEAD, 2'b00, a};
  endfunction

  always @(posedge clk) begin
    if (mem_en === 1'b1 && mem_we == 4'h0) mem_rdata <= pat(mem_addr);
  end

  int cyc_n = 0;
  always @(posedge clk) cyc_n <= cyc_n + 1;

  int checks = 0;
  int errors = 0;

  typedef struct {
    int            cyc;
    bit            core_g;
    bit            con_g;
    bit            en;
    logic [3:0]    we;
    logic [AB-1:0] addr;
    logic [31:0]   wdata;
  } gexp_t;

  typedef struct {
    int          cyc;
    bit          con;
    logic [31:0] data;
  } rexp_t;

  gexp_t gq[$];
  rexp_t rq[$];

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s cycle %0d: got %h expected %h", name, cyc_n, act, exp);
    end
  endtask

  // Monitor: grant/memory port every cycle, read returns whenever presented.
  always @(negedge clk) begin : monitor
    gexp_t e;
    rexp_t r;
    if (gq.size() > 0) begin
      e = gq.pop_front();
      chk("core_gnt",  32'(core_gnt),  32'(e.core_g));
      chk("con_gnt",   32'(con_gnt),   32'(e.con_g));
      chk("mem_en",    32'(mem_en),    32'(e.en));
      chk("mem_we",    32'(mem_we),    32'(e.we));
      chk("mem_addr",  32'(mem_addr),  32'(e.addr));
      chk("mem_wdata", mem_wdata,      e.wdata);
    end
    while (rq.size() > 0 && rq[0].cyc < cyc_n) begin
      r = rq.pop_front();
      checks++;
      errors++;
      $display("FAIL rvalid_missing cycle %0d: got none expected owner con=%0d",
               r.cyc, r.con);
    end
    if (core_rvalid !== 1'b0 || con_rvalid !== 1'b0) begin
      if (rq.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL rvalid_unexpected cycle %0d: got core=%b con=%b expected none",
                 cyc_n, core_rvalid, con_rvalid);
      end else begin
        r = rq.pop_front();
        chk("rv_cycle",    32'(cyc_n),       32'(r.cyc));
        chk("core_rvalid", 32'(core_rvalid), 32'(!r.con));
        chk("con_rvalid",  32'(con_rvalid),  32'(r.con));
        chk("rdata", r.con ? con_rdata : core_rdata, r.data);
      end
    end
  end

  bit            pend_vld = 1'b0;
  bit            pend_con = 1'b0;
  logic [AB-1:0] pend_addr = '0;

  task automatic core_set(input bit req, input logic [3:0] we,
                          input logic [AB-1:0] a, input logic [31:0] wd);
    core_req = req; core_we = we; core_addr = a; core_wdata = wd;
  endtask

  task automatic con_set(input bit req, input logic [3:0] we,
                         input logic [AB-1:0] a, input logic [31:0] wd);
    con_req = req; con_we = we; con_addr = a; con_wdata = wd;
  endtask

  // One clock cycle: apply rst/lock, record the hand-computed winner eg.
  task automatic cyc(input bit r, input bit lock, input int eg);
    gexp_t e;
    rst      = r;
    con_lock = lock;
    // Read granted last cycle returns now, unless reset swallows it.
    if (pend_vld && !r) begin
      rexp_t x;
      x.cyc  = cyc_n;
      x.con  = pend_con;
      x.data = pat(pend_addr);
      rq.push_back(x);
    end
    e.cyc    = cyc_n;
    e.core_g = (eg == G_CORE);
    e.con_g  = (eg == G_CON);
    e.en     = (eg != G_NONE);
    e.we     = (eg == G_CORE) ? core_we    : (eg == G_CON) ? con_we    : 4'h0;
    e.addr   = (eg == G_CORE) ? core_addr  : (eg == G_CON) ? con_addr  : '0;
    e.wdata  = (eg == G_CORE) ? core_wdata : (eg == G_CON) ? con_wdata : 32'h0;
    gq.push_back(e);
    pend_vld  = ((eg == G_CORE) && core_we == 4'h0) ||
                ((eg == G_CON)  && con_we  == 4'h0);
    pend_con  = (eg == G_CON);
    pend_addr = (eg == G_CON) ? con_addr : core_addr;
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    core_set(1'b0, 4'h0, '0, 32'h0);
    con_set(1'b0, 4'h0, '0, 32'h0);
    cyc(1'b0, 1'b0, G_NONE);
  endtask

  initial begin
    rst = 1'b1;
    con_lock = 1'b0;
    core_set(1'b1, 4'h0, 14'h001, 32'h0);
    con_set(1'b1, 4'h0, 14'h002, 32'h0);
    @(posedge clk);
    #1;

    // Reset: requests present but everything forced off.
    cyc(1'b1, 1'b0, G_NONE);
    cyc(1'b1, 1'b0, G_NONE);
    idle();

    // Core-only read of 0x010, data returns next cycle.
    core_set(1'b1, 4'h0, 14'h010, 32'h0);
    cyc(1'b0, 1'b0, G_CORE);
    idle();

    // Contention with STARVE_MAX=4: core x4, console x1, repeating.
    // Reads every cycle also exercise back-to-back alternating returns.
    core_set(1'b1, 4'h0, 14'h040, 32'h0);
    con_set(1'b1, 4'h0, 14'h041, 32'h0);
    for (int i = 0; i < 10; i++) cyc(1'b0, 1'b0, (i % 5 == 4) ? G_CON : G_CORE);
    idle();

    // Interleave: build starve count to 3, core read 0x020 promotes PRI_CON,
    // console read 0x021 wins next cycle even with core still requesting.
    core_set(1'b1, 4'h0, 14'h022, 32'h0);
    con_set(1'b1, 4'h0, 14'h021, 32'h0);
    for (int i = 0; i < 3; i++) cyc(1'b0, 1'b0, G_CORE);
    core_set(1'b1, 4'h0, 14'h020, 32'h0);
    cyc(1'b0, 1'b0, G_CORE);
    cyc(1'b0, 1'b0, G_CON);
    idle();

    // Writes: console partial write, then core full write; no rvalid after.
    con_set(1'b1, 4'b0011, 14'h035, 32'hDEADBEEF);
    cyc(1'b0, 1'b0, G_CON);
    idle();
    core_set(1'b1, 4'b1111, 14'h036, 32'h12345678);
    cyc(1'b0, 1'b0, G_CORE);
    idle();

    // Lock: raised with nobody requesting, then core fenced for 10 cycles
    // while the console alternates; core wins the cycle after release.
    cyc(1'b0, 1'b1, G_NONE);
    for (int i = 0; i < 10; i++) begin
      core_set(1'b1, 4'h0, 14'h050, 32'h0);
      con_set((i % 2) == 0, 4'h0, 14'h051, 32'h0);
      cyc(1'b0, 1'b1, ((i % 2) == 0) ? G_CON : G_NONE);
    end
    con_set(1'b0, 4'h0, 14'h051, 32'h0);
    cyc(1'b0, 1'b0, G_NONE);
    cyc(1'b0, 1'b0, G_CORE);
    idle();

    // Reset mid-operation: starve count 3 and a read in flight; the read
    // must not return and arbitration restarts from PRI_CORE with count 0.
    core_set(1'b1, 4'h0, 14'h060, 32'h0);
    con_set(1'b1, 4'h0, 14'h061, 32'h0);
    for (int i = 0; i < 3; i++) cyc(1'b0, 1'b0, G_CORE);
    cyc(1'b1, 1'b0, G_NONE);
    for (int i = 0; i < 5; i++) cyc(1'b0, 1'b0, (i == 4) ? G_CON : G_CORE);
    idle();
    idle();

    chk("grant_queue_drained", 32'(gq.size()), 32'd0);
    chk("read_queue_drained",  32'(rq.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
